param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised modulo-N up/down counter with synchronous load, count enable
//   and selectable wrap or saturate behaviour at the range limits.
//   General-purpose timing/sequencing counter for the sequential-circuit library.
//   Supersedes the fixed 4-bit down counter. Adds width/modulus generics, direction
//   control, load, terminal-count and wrap/saturation status.
// PARAMETERS
//   WIDTH     4    counter width in bits; WIDTH >= 1
//   MODULUS   16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   RST_VAL   0    count value after reset; must be < MODULUS
//   SAT_MODE  0    0 = wrap at limits; 1 = saturate (hold) at limits
// PORTS
//   clk       in   1      rising-edge clock; the only clock
//   rst       in   1      synchronous, active-low reset; sampled on posedge clk
//   en        in   1      count enable; 1 = step count this cycle
//   up_dn     in   1      direction: 1 = count up, 0 = count down
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value loaded when load = 1
//   count     out  WIDTH  registered counter value
//   tc        out  1      terminal count (combinational from count and up_dn)
//   wrap      out  1      registered 1-cycle pulse: a limit was crossed or hit
//   ovf       out  1      sticky flag: set by any wrap pulse
// BEHAVIOUR
//   - All state updates on posedge clk only.
//   - Priority per cycle: rst == 0 > load > en. The lower-priority inputs are ignored.
//   - Reset (rst == 0): count = RST_VAL, wrap = 0, ovf = 0.
//   - Load (load == 1):
//       count = load_val when load_val < MODULUS, else MODULUS-1 (clamped).
//       wrap = 0; ovf = 0 (load clears the sticky flag). en is ignored.
//   - Count (en == 1, load == 0): latency is 1 cycle; count changes on the next edge.
//       up, count < MODULUS-1:  count + 1, wrap = 0
//       up, count == MODULUS-1: SAT_MODE=0 -> 0;           SAT_MODE=1 -> hold
//       dn, count > 0:          count - 1, wrap = 0
//       dn, count == 0:         SAT_MODE=0 -> MODULUS-1;   SAT_MODE=1 -> hold
//     At a limit, wrap = 1 for exactly that cycle in both modes, and ovf is set to 1.
//   - Idle (en == 0, load == 0): count holds, wrap = 0, ovf holds.
//   - tc = (up_dn && count == MODULUS-1) || (!up_dn && count == 0).
//     tc is combinational, so a direction change updates tc in the same cycle.
//   - Arithmetic is done modulo MODULUS, not 2**WIDTH. For non-power-of-2 MODULUS,
//     count never exceeds MODULUS-1.
//   - Direction may change on any cycle. The step taken uses up_dn as sampled at that edge.
//   - Reset asserted mid-count wins immediately at the next edge. No partial step occurs.
//   - Holding in saturate mode with en = 1 at a limit repeats wrap = 1 on each such cycle.
// TESTING
//   1. WIDTH=4, MODULUS=16, SAT_MODE=0: rst=0 for 1 edge, then en=1, up_dn=0.
//      -> count sequence 0,15,14,...; wrap=1 on the 0->15 step only; ovf=1 afterwards.
//   2. MODULUS=10, up_dn=1, en=1 from 0 -> count 0..9 then 0;
//      tc=1 while count==9; wrap pulses once per 10 cycles.
//   3. MODULUS=10, SAT_MODE=1, load=1 with load_val=8, then up count for 4 cycles
//      -> count 8,9,9,9; wrap=1 on each of the last 2 cycles; ovf=1.
//   4. MODULUS=10, load_val=13 with load=1 and en=1 in the same cycle
//      -> count=9 (clamped); ovf cleared; no step taken.
//   5. Mid-count (count=5, en=1): drive rst=0 and load=1 together
//      -> count=RST_VAL, wrap=0, ovf=0 at the next edge.
//   6. count=0, en=0, toggle up_dn 1->0
//      -> tc goes 0->1 in the same cycle; count unchanged.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// The master drives the step/load controls; the slave (the counter) returns count and status.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, count enable and
// wrap-around or saturate-and-hold behaviour at the range limits.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int RST_VAL  = 0,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    param_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RST_VAL);
    // One extra bit so MODULUS == 2**WIDTH is still representable for the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             at_top;
    logic             at_bottom;
    logic             at_limit;
    logic             load_in_range;

    assign at_top        = (count_q == MAX_VAL);
    assign at_bottom     = (count_q == '0);
    assign at_limit      = bus.up_dn ? at_top : at_bottom;
    assign load_in_range = ({1'b0, bus.load_val} < MOD_EXT);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            count_d = load_in_range ? bus.load_val : MAX_VAL;
            ovf_d   = 1'b0;
        end else if (bus.en) begin
            if (at_limit) begin
                // Limit reached: flag it in both modes; only wrap mode moves the count.
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (!SAT_MODE) begin
                    count_d = bus.up_dn ? '0 : MAX_VAL;
                end
            end else begin
                count_d = bus.up_dn ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= INIT_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = at_limit;

endmodule

// File: tb/tb_param_updown_counter.sv
// Three counter configurations driven with shared stimulus and checked every
// cycle against a modulo-arithmetic reference model, plus pinned directed cases.
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r  = 1'b0;
    logic       en_r   = 1'b0;
    logic       up_r   = 1'b0;
    logic       load_r = 1'b0;
    logic [3:0] lv_r   = 4'd0;

    int nvec = 0;
    int nerr = 0;

    param_updown_counter_if #(.WIDTH(4)) ifa ();
    param_updown_counter_if #(.WIDTH(4)) ifb ();
    param_updown_counter_if #(.WIDTH(4)) ifc ();

    assign ifa.en = en_r;  assign ifa.up_dn = up_r;  assign ifa.load = load_r;  assign ifa.load_val = lv_r;
    assign ifb.en = en_r;  assign ifb.up_dn = up_r;  assign ifb.load = load_r;  assign ifb.load_val = lv_r;
    assign ifc.en = en_r;  assign ifc.up_dn = up_r;  assign ifc.load = load_r;  assign ifc.load_val = lv_r;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0), .SAT_MODE(1'b0))
        dut_a (.clk(clk), .rst(rst_r), .bus(ifa));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0), .SAT_MODE(1'b0))
        dut_b (.clk(clk), .rst(rst_r), .bus(ifb));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(3), .SAT_MODE(1'b1))
        dut_c (.clk(clk), .rst(rst_r), .bus(ifc));

    // Reference model: index 0 = a, 1 = b, 2 = c
    int mod_p[3] = '{16, 10, 10};
    int sat_p[3] = '{0, 0, 1};
    int rv_p[3]  = '{0, 0, 3};
    int m_count[3];
    int m_wrap[3];
    int m_ovf[3];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int hit;
            int nxt;
            if (!rst_r) begin
                m_count[i] = rv_p[i];
                m_wrap[i]  = 0;
                m_ovf[i]   = 0;
            end else if (load_r) begin
                m_count[i] = (int'(lv_r) < mod_p[i]) ? int'(lv_r) : mod_p[i] - 1;
                m_wrap[i]  = 0;
                m_ovf[i]   = 0;
            end else if (en_r) begin
                hit = up_r ? (m_count[i] == mod_p[i] - 1) : (m_count[i] == 0);
                nxt = up_r ? (m_count[i] + 1) % mod_p[i] : (m_count[i] + mod_p[i] - 1) % mod_p[i];
                if (hit && sat_p[i] != 0) nxt = m_count[i];
                m_count[i] = nxt;
                m_wrap[i]  = hit;
                if (hit) m_ovf[i] = 1;
            end else begin
                m_wrap[i] = 0;
            end
        end
        if (!rst_r) m_valid = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_tc(int i);
        return (up_r && m_count[i] == mod_p[i] - 1) || (!up_r && m_count[i] == 0);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a.count", 32'(ifa.count), 32'(m_count[0]));
            chk("a.wrap",  32'(ifa.wrap),  32'(m_wrap[0]));
            chk("a.ovf",   32'(ifa.ovf),   32'(m_ovf[0]));
            chk("a.tc",    32'(ifa.tc),    32'(model_tc(0)));
            chk("b.count", 32'(ifb.count), 32'(m_count[1]));
            chk("b.wrap",  32'(ifb.wrap),  32'(m_wrap[1]));
            chk("b.ovf",   32'(ifb.ovf),   32'(m_ovf[1]));
            chk("b.tc",    32'(ifb.tc),    32'(model_tc(1)));
            chk("c.count", 32'(ifc.count), 32'(m_count[2]));
            chk("c.wrap",  32'(ifc.wrap),  32'(m_wrap[2]));
            chk("c.ovf",   32'(ifc.ovf),   32'(m_ovf[2]));
            chk("c.tc",    32'(ifc.tc),    32'(model_tc(2)));
        end
    end

    // Drive inputs for one edge, then return just after that edge.
    task automatic apply(input bit r, input bit e, input bit u, input bit l, input int v);
        rst_r  = r;
        en_r   = e;
        up_r   = u;
        load_r = l;
        lv_r   = 4'(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        apply(0, 0, 0, 0, 0);
        chk("rst a.count", 32'(ifa.count), 32'd0);
        chk("rst c.count", 32'(ifc.count), 32'd3);
        chk("rst a.wrap",  32'(ifa.wrap),  32'd0);
        chk("rst a.ovf",   32'(ifa.ovf),   32'd0);

        // Down from 0 wraps to the top
        apply(1, 1, 0, 0, 0);
        chk("dn a.count", 32'(ifa.count), 32'd15);
        chk("dn a.wrap",  32'(ifa.wrap),  32'd1);
        chk("dn a.ovf",   32'(ifa.ovf),   32'd1);
        chk("dn b.count", 32'(ifb.count), 32'd9);
        chk("dn c.count", 32'(ifc.count), 32'd2);
        apply(1, 1, 0, 0, 0);
        chk("dn2 a.count", 32'(ifa.count), 32'd14);
        chk("dn2 a.wrap",  32'(ifa.wrap),  32'd0);
        chk("dn2 a.ovf",   32'(ifa.ovf),   32'd1);

        // Modulo-10 up count
        apply(0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) apply(1, 1, 1, 0, 0);
        chk("up9 b.count", 32'(ifb.count), 32'd9);
        chk("up9 b.tc",    32'(ifb.tc),    32'd1);
        chk("up9 b.wrap",  32'(ifb.wrap),  32'd0);
        apply(1, 1, 1, 0, 0);
        chk("up10 b.count", 32'(ifb.count), 32'd0);
        chk("up10 b.wrap",  32'(ifb.wrap),  32'd1);
        chk("up10 b.tc",    32'(ifb.tc),    32'd0);

        // Saturate at the top
        apply(1, 0, 1, 1, 8);
        chk("ld8 c.count", 32'(ifc.count), 32'd8);
        chk("ld8 b.ovf",   32'(ifb.ovf),   32'd0);
        apply(1, 1, 1, 0, 0);
        chk("sat1 c.count", 32'(ifc.count), 32'd9);
        chk("sat1 c.wrap",  32'(ifc.wrap),  32'd0);
        apply(1, 1, 1, 0, 0);
        chk("sat2 c.count", 32'(ifc.count), 32'd9);
        chk("sat2 c.wrap",  32'(ifc.wrap),  32'd1);
        chk("sat2 c.ovf",   32'(ifc.ovf),   32'd1);
        apply(1, 1, 1, 0, 0);
        chk("sat3 c.count", 32'(ifc.count), 32'd9);
        chk("sat3 c.wrap",  32'(ifc.wrap),  32'd1);

        // Out-of-range load clamps; load beats en and clears ovf
        apply(1, 1, 1, 1, 13);
        chk("ld13 b.count", 32'(ifb.count), 32'd9);
        chk("ld13 c.count", 32'(ifc.count), 32'd9);
        chk("ld13 a.count", 32'(ifa.count), 32'd13);
        chk("ld13 c.ovf",   32'(ifc.ovf),   32'd0);
        chk("ld13 c.wrap",  32'(ifc.wrap),  32'd0);

        // Reset beats load mid-count
        apply(1, 0, 1, 1, 4);
        apply(1, 1, 1, 0, 0);
        chk("mid b.count", 32'(ifb.count), 32'd5);
        apply(0, 1, 1, 1, 7);
        chk("rl a.count", 32'(ifa.count), 32'd0);
        chk("rl c.count", 32'(ifc.count), 32'd3);
        chk("rl a.ovf",   32'(ifa.ovf),   32'd0);

        // tc follows direction combinationally
        apply(1, 0, 1, 0, 0);
        chk("tc up a.tc", 32'(ifa.tc), 32'd0);
        up_r = 1'b0;
        #1;
        chk("tc dn a.tc",    32'(ifa.tc),    32'd1);
        chk("tc dn a.count", 32'(ifa.count), 32'd0);

        // Random stimulus, checked by the per-cycle compare
        for (int k = 0; k < 3000; k++) begin
            apply($urandom_range(0, 31) != 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
